// File: rtl/comb_pkg.sv
// Shared definitions for the r-of-N combination mask generator: state
// encoding and the trailing-zero helper used by Gosper's successor.
package comb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_FIN  = ST_FIN
  } state_e;

  // Index of the lowest set bit; 32 when the vector is zero. The loop runs
  // downwards so the last (lowest) hit wins -- a priority encoder in hardware.
  function automatic int trailing_zeros(input logic [31:0] v);
    int tz;
    tz = 32;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) tz = i;
    end
    return tz;
  endfunction

endpackage

// File: rtl/comb_next_mask.sv
// Gosper's successor: the next larger SIZE-bit value with the same popcount.
// Evaluated in SIZE+1 bits so running off the top shows up as wrap.
module comb_next_mask
  import comb_pkg::*;
#(
  parameter int SIZE = 5
) (
  input  logic [SIZE-1:0] x,
  output logic [SIZE-1:0] nxt,
  output logic            wrap
);

  logic [SIZE:0] xe;
  logic [SIZE:0] lsb;
  logic [SIZE:0] sum;
  logic [SIZE:0] ripple;
  logic [SIZE:0] full;

  // Isolate the lowest one, carry it upward, then refill the freed ones at the bottom.
  always_comb begin
    xe     = {1'b0, x};
    lsb    = xe & (-xe);
    sum    = xe + lsb;
    ripple = ((sum ^ xe) >> 2) >> trailing_zeros(32'(xe));
    full   = sum | ripple;
  end

  assign nxt  = full[SIZE-1:0];
  assign wrap = full[SIZE];

endmodule

// File: rtl/comb_mask_generator.sv
// Streams every SIZE-bit mask with exactly r ones, in ascending order, one
// per valid/ready transfer. rst_n is expected to be deasserted synchronously
// by the upstream reset tree.
module comb_mask_generator
  import comb_pkg::*;
#(
  parameter int SIZE      = 5,
  parameter int R_WIDTH   = 3,
  parameter int IDX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [R_WIDTH-1:0]   r,
  output logic [SIZE-1:0]      mask,
  output logic                 mask_valid,
  input  logic                 mask_ready,
  output logic                 mask_last,
  output logic [IDX_WIDTH-1:0] mask_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e               state_q;
  logic [SIZE-1:0]      mask_q;
  logic                 valid_q;
  logic                 last_q;
  logic [IDX_WIDTH-1:0] idx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;

  logic [SIZE-1:0]      first_mask;
  logic                 r_too_big;
  logic [SIZE-1:0]      succ_mask;
  logic                 succ_wrap;
  logic [SIZE-1:0]      step_mask;
  logic [SIZE-1:0]      load_mask;
  logic                 load_wrap;
  logic                 load_last;

  // Lowest combination for the requested count: the r low bits set.
  // NOTE: every always_comb output gets a value on every path (here via the
  // loop covering all bits), otherwise synthesis infers a latch.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      first_mask[i] = (i < int'(r));
    end
  end

  assign r_too_big = int'(r) > SIZE;

  comb_next_mask #(.SIZE(SIZE)) u_step (
    .x    (mask_q),
    .nxt  (succ_mask),
    .wrap (succ_wrap)
  );

  // Never advance past the top combination, even if asked to.
  assign step_mask = succ_wrap ? mask_q : succ_mask;

  // The value about to be loaded; its own successor decides mask_last so the
  // flag is registered together with the mask it describes.
  assign load_mask = (state_q == S_IDLE) ? first_mask : step_mask;

  comb_next_mask #(.SIZE(SIZE)) u_ahead (
    .x    (load_mask),
    .nxt  (),
    .wrap (load_wrap)
  );

  // r == 0 has no successor at all (Gosper maps 0 to 0), so flag it directly.
  assign load_last = load_wrap | (load_mask == '0);

  // Control FSM with registered outputs: start/err in IDLE, handshake in RUN, done in FIN.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (r_too_big) begin
              err_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              valid_q <= 1'b1;
              idx_q   <= '0;
              mask_q  <= load_mask;
              last_q  <= load_last;
            end
          end
        end
        S_RUN: begin
          if (valid_q && mask_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              mask_q <= load_mask;
              idx_q  <= idx_q + IDX_WIDTH'(1);
              last_q <= load_last;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mask       = mask_q;
  assign mask_valid = valid_q;
  assign mask_last  = last_q;
  assign mask_idx   = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_comb_mask_generator.sv
// Self-checking bench for comb_mask_generator: expected sequences are the
// ascending list of all SIZE-bit values with popcount r.
module tb_comb_mask_generator;

  localparam int SIZE      = 5;
  localparam int R_WIDTH   = 3;
  localparam int IDX_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [R_WIDTH-1:0]   r;
  logic [SIZE-1:0]      mask;
  logic                 mask_valid;
  logic                 mask_ready;
  logic                 mask_last;
  logic [IDX_WIDTH-1:0] mask_idx;
  logic                 busy;
  logic                 done;
  logic                 err;

  int checks = 0;
  int errors = 0;

  comb_mask_generator #(
    .SIZE      (SIZE),
    .R_WIDTH   (R_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .r          (r),
    .mask       (mask),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready),
    .mask_last  (mask_last),
    .mask_idx   (mask_idx),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mask"},  32'(mask), 0);
    check({tag, "_valid"}, 32'(mask_valid), 0);
    check({tag, "_last"},  32'(mask_last), 0);
    check({tag, "_idx"},   32'(mask_idx), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_err"},   32'(err), 0);
  endtask

  // Start a sequence for count rr and follow it to done. ready_pct sets how
  // often mask_ready is high; poke drives stray r=1 starts during the run;
  // abort_after > 0 pulls rst_n low once that many transfers have completed.
  task automatic run_seq(input int rr, input int ready_pct, input bit poke, input int abort_after);
    int  exp_q[$];
    int  n;
    int  cyc;
    bit  xfer;
    for (int v = 0; v < (1 << SIZE); v++) begin
      if ($countones(v) == rr) exp_q.push_back(v);
    end
    @(negedge clk);
    start      = 1'b1;
    r          = R_WIDTH'(rr);
    mask_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n   = 0;
    cyc = 0;
    while (n < exp_q.size() && cyc < 500) begin
      if (abort_after > 0 && n == abort_after) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      check("run_valid", 32'(mask_valid), 1);
      check("run_busy",  32'(busy), 1);
      check("run_mask",  32'(mask), 32'(exp_q[n]));
      check("run_idx",   32'(mask_idx), 32'(n));
      check("run_last",  32'(mask_last), 32'(n == exp_q.size() - 1));
      check("run_pop",   32'($countones(mask)), 32'(rr));
      check("run_err",   32'(err), 0);
      check("run_done",  32'(done), 0);
      mask_ready = ($urandom_range(0, 99) < ready_pct);
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        r     = R_WIDTH'(1);
      end
      xfer = mask_valid && mask_ready;
      @(negedge clk);
      cyc++;
      if (xfer) n++;
    end
    start = 1'b0;
    check("seq_complete", 32'(n), 32'(exp_q.size()));
    check("fin_done",  32'(done), 1);
    check("fin_valid", 32'(mask_valid), 0);
    check("fin_busy",  32'(busy), 0);
    check("fin_err",   32'(err), 0);
    @(negedge clk);
    check("idle_done", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  task automatic err_case(input int rr);
    @(negedge clk);
    start = 1'b1;
    r     = R_WIDTH'(rr);
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", 32'(err), 1);
    check("err_valid", 32'(mask_valid), 0);
    check("err_busy",  32'(busy), 0);
    check("err_done",  32'(done), 0);
    @(negedge clk);
    check("err_clear", 32'(err), 0);
    check("err_valid2", 32'(mask_valid), 0);
    check("err_busy2", 32'(busy), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    r          = '0;
    mask_ready = 1'b0;
    @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_seq(2, 100, 1'b0, 0);
    run_seq(0, 100, 1'b0, 0);
    run_seq(5, 100, 1'b0, 0);
    err_case(6);
    err_case(7);
    run_seq(3, 50, 1'b0, 0);
    run_seq(3, 70, 1'b1, 0);
    run_seq(3, 100, 1'b0, 4);
    run_seq(1, 100, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      run_seq(int'($urandom_range(0, SIZE)), int'($urandom_range(30, 100)), 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
